// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arith/logic ops, iterative shift-add MUL, bit-serial SHIFT.
// Latency 1 cycle (WIDTH+1 for MUL, amount+1 for SHIFT); START ignored while BUSY, never queued.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             START,
   input  logic [2:0]       ALUOP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             CARRY,
   output logic             OVF
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MUL   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;

   localparam logic [2:0] OP_FWD   = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [2:0] OP_SHIFT = 3'b101;
   localparam logic [2:0] OP_SUB   = 3'b110;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;

   // Counter must hold both the MUL iteration index and the largest shift amount.
   localparam int CW = (SHW > $clog2(WIDTH + 1)) ? SHW : $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] SH_LAST  = CW'(1);

   typedef struct packed {
      logic [WIDTH-1:0] acc;
      logic [WIDTH-1:0] mcand;
      logic [WIDTH-1:0] mplier;
      logic [1:0]       mode;
      logic [CW-1:0]    cnt;
   } work_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             carry;
      logic             ovf;
   } out_t;

   logic [1:0]       state;
   work_t            work;
   out_t             imm;
   out_t             fin_dat;
   logic             fin_vld;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] diff;
   logic [1:0]       sh_mode;
   logic [SHW-1:0]   sh_amt;
   logic             accept;
   logic             multi_cycle;
   logic [WIDTH-1:0] mul_nxt;
   logic [WIDTH-1:0] shift_nxt;

   assign BUSY        = (state != S_IDLE);
   assign sh_mode     = DATA2[WIDTH-1 -: 2];
   assign sh_amt      = DATA2[SHW-1:0];
   assign accept      = (state == S_IDLE) && START;
   assign multi_cycle = (ALUOP == OP_MUL) || ((ALUOP == OP_SHIFT) && (sh_amt != '0));

   always_comb begin
      sum_ext   = {1'b0, DATA1} + {1'b0, DATA2};
      diff      = DATA1 - DATA2;
      imm.res   = '0;
      imm.carry = 1'b0;
      imm.ovf   = 1'b0;
      case (ALUOP)
         OP_FWD: imm.res = DATA2;
         OP_ADD: begin
            imm.res   = sum_ext[WIDTH-1:0];
            imm.carry = sum_ext[WIDTH];
            imm.ovf   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum_ext[WIDTH-1] != DATA1[WIDTH-1]);
         end
         OP_AND:   imm.res = DATA1 & DATA2;
         OP_OR:    imm.res = DATA1 | DATA2;
         OP_SHIFT: imm.res = DATA1;
         OP_SUB: begin
            imm.res   = diff;
            imm.carry = (DATA1 >= DATA2);
            imm.ovf   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff[WIDTH-1] != DATA1[WIDTH-1]);
         end
         default: imm.res = '0;
      endcase
   end

   always_comb begin
      mul_nxt = work.acc + (work.mplier[0] ? work.mcand : '0);
   end

   always_comb begin
      case (work.mode)
         SH_LSL:  shift_nxt = {work.acc[WIDTH-2:0], 1'b0};
         SH_LSR:  shift_nxt = {1'b0, work.acc[WIDTH-1:1]};
         SH_ASR:  shift_nxt = {work.acc[WIDTH-1], work.acc[WIDTH-1:1]};
         default: shift_nxt = {work.acc[0], work.acc[WIDTH-1:1]};
      endcase
   end

   // Single point where an operation retires; drives DONE and the result registers.
   always_comb begin
      fin_vld = 1'b0;
      fin_dat = '0;
      case (state)
         S_IDLE: begin
            if (accept && !multi_cycle) begin
               fin_vld = 1'b1;
               fin_dat = imm;
            end
         end
         S_MUL: begin
            if (work.cnt == MUL_LAST) begin
               fin_vld     = 1'b1;
               fin_dat.res = mul_nxt;
            end
         end
         S_SHIFT: begin
            if (work.cnt == SH_LAST) begin
               fin_vld     = 1'b1;
               fin_dat.res = shift_nxt;
            end
         end
         default: fin_vld = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= S_IDLE;
         work  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && (ALUOP == OP_MUL)) begin
                  state       <= S_MUL;
                  work.acc    <= '0;
                  work.mcand  <= DATA1;
                  work.mplier <= DATA2;
                  work.cnt    <= '0;
               end else if (accept && multi_cycle) begin
                  state     <= S_SHIFT;
                  work.acc  <= DATA1;
                  work.mode <= sh_mode;
                  work.cnt  <= CW'(sh_amt);
               end
            end
            S_MUL: begin
               work.acc    <= mul_nxt;
               work.mcand  <= {work.mcand[WIDTH-2:0], 1'b0};
               work.mplier <= {1'b0, work.mplier[WIDTH-1:1]};
               work.cnt    <= work.cnt + CW'(1);
               if (work.cnt == MUL_LAST) begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               work.acc <= shift_nxt;
               work.cnt <= work.cnt - CW'(1);
               if (work.cnt == SH_LAST) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         DONE   <= 1'b0;
         RESULT <= '0;
         ZERO   <= 1'b1;
         CARRY  <= 1'b0;
         OVF    <= 1'b0;
      end else begin
         DONE <= fin_vld;
         if (fin_vld) begin
            RESULT <= fin_dat.res;
            ZERO   <= (fin_dat.res == '0);
            CARRY  <= fin_dat.carry;
            OVF    <= fin_dat.ovf;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: WIDTH=8 and WIDTH=16 instances checked every cycle against a timeline model.
module tb_seq_alu;

   logic CLK   = 1'b0;
   logic rst_n = 1'b1;
   always #5 CLK = ~CLK;

   logic        st  [2];
   logic [2:0]  opc [2];
   logic [31:0] d1  [2];
   logic [31:0] d2  [2];

   logic        busy8, done8, zero8, carry8, ovf8;
   logic [7:0]  res8;
   logic        busy16, done16, zero16, carry16, ovf16;
   logic [15:0] res16;

   seq_alu #(.WIDTH(8)) u_alu8 (
      .CLK(CLK), .RESETN(rst_n), .START(st[0]), .ALUOP(opc[0]),
      .DATA1(d1[0][7:0]), .DATA2(d2[0][7:0]),
      .BUSY(busy8), .DONE(done8), .RESULT(res8), .ZERO(zero8), .CARRY(carry8), .OVF(ovf8)
   );

   seq_alu #(.WIDTH(16)) u_alu16 (
      .CLK(CLK), .RESETN(rst_n), .START(st[1]), .ALUOP(opc[1]),
      .DATA1(d1[1][15:0]), .DATA2(d2[1][15:0]),
      .BUSY(busy16), .DONE(done16), .RESULT(res16), .ZERO(zero16), .CARRY(carry16), .OVF(ovf16)
   );

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        zero;
      logic        carry;
      logic        ovf;
      logic [31:0] res;
   } obs_t;

   // Model state: expected registered outputs plus the one operation in flight per instance.
   int          k = 0;
   bit          pend   [2];
   int          upd_e  [2];
   int          free_e [2];
   logic [31:0] p_r    [2];
   bit          p_c    [2];
   bit          p_v    [2];
   logic [31:0] e_r    [2];
   bit          e_z    [2];
   bit          e_c    [2];
   bit          e_v    [2];
   bit          e_done [2];
   bit          e_busy [2];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 16;
   endfunction

   function automatic obs_t obs(input int i);
      obs_t o;
      if (i == 0) begin
         o.busy = busy8;  o.done = done8;  o.zero = zero8;
         o.carry = carry8; o.ovf = ovf8;   o.res = {24'd0, res8};
      end else begin
         o.busy = busy16; o.done = done16; o.zero = zero16;
         o.carry = carry16; o.ovf = ovf16; o.res = {16'd0, res16};
      end
      return o;
   endfunction

   // Result, flags and DONE latency of one operation, from plain integer arithmetic.
   function automatic void model_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r, output bit c,
                                    output bit v, output int lat);
      longint unsigned mask, ua, ub, t;
      longint          sa, sb, sr, smax, smin;
      int              amt, mode, n, shw;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      smax = (64'sd1 <<< (w - 1)) - 64'sd1;
      smin = -(smax + 64'sd1);
      sa   = $signed(ua[w-1] ? ua - mask - 64'd1 : ua);
      sb   = $signed(ub[w-1] ? ub - mask - 64'd1 : ub);
      shw  = $clog2(w);
      r = '0; c = 1'b0; v = 1'b0; lat = 1;
      case (op)
         3'd0: r = 32'(ub);
         3'd1: begin
            t  = ua + ub;
            r  = 32'(t & mask);
            c  = (t >> w) != 64'd0;
            sr = sa + sb;
            v  = (sr > smax) || (sr < smin);
         end
         3'd2: r = 32'(ua & ub);
         3'd3: r = 32'(ua | ub);
         3'd4: begin
            r   = 32'((ua * ub) & mask);
            lat = w + 1;
         end
         3'd5: begin
            mode = int'((ub >> (w - 2)) & 64'd3);
            amt  = int'(ub & ((64'd1 << shw) - 64'd1));
            if (amt == 0) begin
               r = 32'(ua);
            end else begin
               lat = amt + 1;
               case (mode)
                  0: r = 32'((ua << amt) & mask);
                  1: r = 32'(ua >> amt);
                  2: r = 32'($unsigned(sa >>> amt) & mask);
                  default: begin
                     n = amt % w;
                     r = 32'(((ua >> n) | (ua << (w - n))) & mask);
                  end
               endcase
            end
         end
         3'd6: begin
            r  = 32'((ua - ub) & mask);
            c  = ua >= ub;
            sr = sa - sb;
            v  = (sr > smax) || (sr < smin);
         end
         default: r = '0;
      endcase
   endfunction

   initial begin : model
      logic [31:0] r;
      bit          c, v;
      int          lat;
      forever begin
         @(posedge CLK or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
               pend[i] = 1'b0; free_e[i] = 0;
               e_r[i] = '0; e_z[i] = 1'b1; e_c[i] = 1'b0; e_v[i] = 1'b0;
               e_done[i] = 1'b0; e_busy[i] = 1'b0;
            end
         end else begin
            k++;
            for (int i = 0; i < 2; i++) begin
               e_done[i] = 1'b0;
               if (pend[i] && k == upd_e[i]) begin
                  e_r[i] = p_r[i]; e_z[i] = (p_r[i] == 32'd0); e_c[i] = p_c[i]; e_v[i] = p_v[i];
                  e_done[i] = 1'b1;
                  pend[i] = 1'b0;
               end
               if (st[i] && k >= free_e[i]) begin
                  model_op(wid(i), opc[i], d1[i], d2[i], r, c, v, lat);
                  if (lat == 1) begin
                     e_r[i] = r; e_z[i] = (r == 32'd0); e_c[i] = c; e_v[i] = v;
                     e_done[i] = 1'b1;
                  end else begin
                     pend[i] = 1'b1; p_r[i] = r; p_c[i] = c; p_v[i] = v;
                     upd_e[i] = k + lat - 1;
                  end
                  free_e[i] = k + lat;
               end
               e_busy[i] = pend[i];
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      obs_t o;
      for (int i = 0; i < 2; i++) begin
         o = obs(i);
         chk($sformatf("w%0d done", wid(i)),  32'(o.done),  32'(e_done[i]));
         chk($sformatf("w%0d busy", wid(i)),  32'(o.busy),  32'(e_busy[i]));
         chk($sformatf("w%0d result", wid(i)), o.res,       e_r[i]);
         chk($sformatf("w%0d zero", wid(i)),  32'(o.zero),  32'(e_z[i]));
         chk($sformatf("w%0d carry", wid(i)), 32'(o.carry), 32'(e_c[i]));
         chk($sformatf("w%0d ovf", wid(i)),   32'(o.ovf),   32'(e_v[i]));
      end
   endtask

   task automatic step();
      @(negedge CLK);
      compare_all();
   endtask

   // Issue one op, scramble inputs after accept, wait for DONE and check literal expectations.
   task automatic do_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit ec, input bit ev, input int elat,
                        input string nm);
      obs_t o;
      int   n;
      step();
      st[i] = 1'b1; opc[i] = op; d1[i] = a; d2[i] = b;
      step();
      st[i] = 1'b0; opc[i] = 3'($urandom_range(0, 7)); d1[i] = $urandom; d2[i] = $urandom;
      n = 0;
      o = obs(i);
      while (!o.done && n < 64) begin
         step();
         n++;
         o = obs(i);
      end
      chk({nm, " latency"}, 32'(n + 1), 32'(elat));
      chk({nm, " result"}, o.res, er);
      chk({nm, " zero"}, 32'(o.zero), 32'(er == 32'd0));
      chk({nm, " carry"}, 32'(o.carry), 32'(ec));
      chk({nm, " ovf"}, 32'(o.ovf), 32'(ev));
   endtask

   initial begin : stim
      logic [31:0] r;
      bit          c, v;
      int          lat, n;
      obs_t        o;
      for (int i = 0; i < 2; i++) begin
         st[i] = 1'b0; opc[i] = '0; d1[i] = '0; d2[i] = '0;
      end
      #1 rst_n = 1'b0;
      step();
      o = obs(0);
      chk("reset zero", 32'(o.zero), 32'd1);
      chk("reset result", o.res, 32'd0);
      step();
      rst_n = 1'b1;

      model_op(8, 3'd1, 32'hFF, 32'h01, r, c, v, lat);
      chk("model add8 r", r, 32'h00); chk("model add8 c", 32'(c), 32'd1); chk("model add8 v", 32'(v), 32'd0);
      model_op(8, 3'd6, 32'h80, 32'h01, r, c, v, lat);
      chk("model sub8 r", r, 32'h7F); chk("model sub8 v", 32'(v), 32'd1);
      model_op(8, 3'd5, 32'h81, 32'hC3, r, c, v, lat);
      chk("model ror8 r", r, 32'h30); chk("model ror8 lat", 32'(lat), 32'd4);
      model_op(16, 3'd4, 32'h00FF, 32'h0101, r, c, v, lat);
      chk("model mul16 r", r, 32'hFFFF); chk("model mul16 lat", 32'(lat), 32'd17);

      do_op(0, 3'd1, 32'hFF, 32'h01, 32'h00, 1, 0, 1, "add8 ff+1");
      do_op(0, 3'd6, 32'h80, 32'h01, 32'h7F, 1, 1, 1, "sub8 80-1");
      do_op(0, 3'd6, 32'h01, 32'h02, 32'hFF, 0, 0, 1, "sub8 borrow");
      do_op(0, 3'd1, 32'h7F, 32'h01, 32'h80, 0, 1, 1, "add8 ovf");
      do_op(0, 3'd4, 32'h0F, 32'h11, 32'hFF, 0, 0, 9, "mul8 0f*11");
      do_op(0, 3'd4, 32'h10, 32'h10, 32'h00, 0, 0, 9, "mul8 10*10");
      do_op(0, 3'd5, 32'h81, 32'hC3, 32'h30, 0, 0, 4, "ror8 3");
      do_op(0, 3'd5, 32'h81, 32'h81, 32'hC0, 0, 0, 2, "asr8 1");
      do_op(0, 3'd5, 32'h81, 32'h00, 32'h81, 0, 0, 1, "shift8 0");
      do_op(0, 3'd5, 32'h81, 32'h02, 32'h04, 0, 0, 3, "lsl8 2");
      do_op(0, 3'd5, 32'h81, 32'h47, 32'h01, 0, 0, 8, "lsr8 7");
      do_op(0, 3'd0, 32'h12, 32'hA5, 32'hA5, 0, 0, 1, "fwd8");
      do_op(0, 3'd2, 32'hF0, 32'h3C, 32'h30, 0, 0, 1, "and8");
      do_op(0, 3'd3, 32'hF0, 32'h0C, 32'hFC, 0, 0, 1, "or8");
      do_op(0, 3'd7, 32'hFF, 32'hFF, 32'h00, 0, 0, 1, "rsvd8");
      do_op(1, 3'd1, 32'hFFFF, 32'h0001, 32'h0000, 1, 0, 1, "add16 ffff+1");
      do_op(1, 3'd6, 32'h8000, 32'h0001, 32'h7FFF, 1, 1, 1, "sub16 8000-1");
      do_op(1, 3'd4, 32'h00FF, 32'h0101, 32'hFFFF, 0, 0, 17, "mul16");
      do_op(1, 3'd4, 32'h0100, 32'h0100, 32'h0000, 0, 0, 17, "mul16 zero");
      do_op(1, 3'd5, 32'h8001, 32'hC003, 32'h3000, 0, 0, 4, "ror16 3");
      do_op(1, 3'd5, 32'h8001, 32'h8001, 32'hC000, 0, 0, 2, "asr16 1");
      do_op(1, 3'd5, 32'h8001, 32'h0000, 32'h8001, 0, 0, 1, "shift16 0");

      // START held through a MUL; the next op is taken in the DONE cycle.
      step();
      st[0] = 1'b1; opc[0] = 3'd4; d1[0] = 32'h0F; d2[0] = 32'h11;
      step();
      n = 0;
      o = obs(0);
      while (!o.done && n < 64) begin
         step();
         n++;
         o = obs(0);
      end
      chk("b2b mul latency", 32'(n + 1), 32'd9);
      chk("b2b mul result", o.res, 32'hFF);
      opc[0] = 3'd2; d1[0] = 32'hF0; d2[0] = 32'h3C;
      step();
      o = obs(0);
      chk("b2b and done", 32'(o.done), 32'd1);
      chk("b2b and result", o.res, 32'h30);
      st[0] = 1'b0;
      step();
      o = obs(0);
      chk("b2b no extra done", 32'(o.done), 32'd0);
      chk("b2b idle", 32'(o.busy), 32'd0);

      // Reset in the middle of MUL iteration 4.
      step();
      st[0] = 1'b1; opc[0] = 3'd4; d1[0] = 32'h0F; d2[0] = 32'h11;
      step();
      st[0] = 1'b0;
      for (int j = 0; j < 3; j++) step();
      #2 rst_n = 1'b0;
      #1;
      o = obs(0);
      chk("rst busy", 32'(o.busy), 32'd0);
      chk("rst done", 32'(o.done), 32'd0);
      chk("rst result", o.res, 32'd0);
      chk("rst zero", 32'(o.zero), 32'd1);
      chk("rst carry", 32'(o.carry), 32'd0);
      chk("rst ovf", 32'(o.ovf), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 12; j++) step();
      do_op(0, 3'd2, 32'hF0, 32'h3C, 32'h30, 0, 0, 1, "and after rst");

      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            st[i]  = ($urandom_range(0, 3) != 0);
            opc[i] = 3'($urandom_range(0, 7));
            d1[i]  = $urandom;
            d2[i]  = $urandom;
         end
         if (cyc % 700 == 350) begin
            #2 rst_n = 1'b0;
         end
         if (cyc % 700 == 353) rst_n = 1'b1;
      end
      for (int i = 0; i < 2; i++) st[i] = 1'b0;
      for (int j = 0; j < 20; j++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
